// File: rtl/user_counter_ctrl.sv
// Run/idle sequencer for a downstream period counter: counts completed periods, raises irq/err pulses.
// Optional auto-reload on completion is enabled by defining USER_CNT_CTRL_AUTORELOAD_EN.
module user_counter_ctrl #(
  parameter int unsigned CntWidth = 16,
  parameter int unsigned RepWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [CntWidth-1:0] period_i,
  input  logic [RepWidth-1:0] repeat_i,
  input  logic                cnt_done_i,
  output logic                cnt_enable_o,
  output logic [CntWidth-1:0] cnt_end_val_o,
  output logic                busy_o,
  output logic [RepWidth-1:0] period_cnt_o,
  output logic                irq_o,
  output logic                err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_reg, state_next;
  logic [CntWidth-1:0] end_val_reg, end_val_next;
  logic [RepWidth-1:0] repeat_reg, repeat_next;
  logic [RepWidth-1:0] period_cnt_reg, period_cnt_next;
  logic                irq_reg, irq_next;
  logic                err_reg, err_next;

  logic [RepWidth-1:0] cnt_inc;
  logic                start_ok;
  logic                last_period;

  assign cnt_inc     = period_cnt_reg + RepWidth'(1);
  assign start_ok    = start_i && !stop_i;
  // A repeat of zero never matches here, so the run continues until stop_i.
  assign last_period = cnt_done_i && (repeat_reg != '0) && (cnt_inc == repeat_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      end_val_reg    <= '0;
      repeat_reg     <= '0;
      period_cnt_reg <= '0;
      irq_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      end_val_reg    <= end_val_next;
      repeat_reg     <= repeat_next;
      period_cnt_reg <= period_cnt_next;
      irq_reg        <= irq_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok && (period_i != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_next = IDLE;
        end else if (last_period) begin
`ifdef USER_CNT_CTRL_AUTORELOAD_EN
          if (period_i == '0) begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    end_val_next    = end_val_reg;
    repeat_next     = repeat_reg;
    period_cnt_next = period_cnt_reg;
    irq_next        = 1'b0;
    err_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          if (period_i != '0) begin
            end_val_next    = period_i;
            repeat_next     = repeat_i;
            period_cnt_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        // stop_i wins over a coincident final done: no count, no irq.
        if (!stop_i && cnt_done_i) begin
          period_cnt_next = cnt_inc;
          if (last_period) begin
            irq_next = 1'b1;
`ifdef USER_CNT_CTRL_AUTORELOAD_EN
            if (period_i != '0) begin
              end_val_next    = period_i;
              repeat_next     = repeat_i;
              period_cnt_next = '0;
            end else begin
              err_next = 1'b1;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  assign cnt_enable_o  = (state_reg == RUN);
  assign busy_o        = (state_reg == RUN);
  assign cnt_end_val_o = end_val_reg;
  assign period_cnt_o  = period_cnt_reg;
  assign irq_o         = irq_reg;
  assign err_o         = err_reg;

endmodule

// File: doc/user_counter_ctrl.md
USER_COUNTER_CTRL -- requirements
Module: user_counter_ctrl

Interface
REQ-001 SHALL have parameter CntWidth, default 16: width of period and counter end value.
REQ-002 SHALL have parameter RepWidth, default 8: width of repeat count and period counter.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port stop_i  input  1  abort request, sampled only in RUN.
REQ-007 SHALL have port period_i  input  CntWidth  period in cycles, latched on accepted start.
REQ-008 SHALL have port repeat_i  input  RepWidth  number of periods; 0 = run until stop.
REQ-009 SHALL have port cnt_done_i  input  1  done from downstream counter (high on its last count).
REQ-010 SHALL have port cnt_enable_o  output  1  enable to downstream counter.
REQ-011 SHALL have port cnt_end_val_o  output  CntWidth  end value to downstream counter.
REQ-012 SHALL have port busy_o  output  1  high while in RUN.
REQ-013 SHALL have port period_cnt_o  output  RepWidth  completed periods since last start.
REQ-014 SHALL have port irq_o  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement FSM with states IDLE and RUN; cnt_enable_o = busy_o = (state == RUN), both registered.
REQ-017 IDLE, start_i=1, period_i!=0, stop_i=0: SHALL latch period_i into cnt_end_val_o and repeat_i internally, clear period_cnt_o and enter RUN on the same edge.
REQ-018 IDLE, start_i=1, period_i==0: SHALL stay IDLE, pulse err_o for one cycle and leave cnt_end_val_o unchanged.
REQ-019 IDLE with start_i and stop_i both high: SHALL stay IDLE with no err_o.
REQ-020 RUN: each edge sampling cnt_done_i=1 SHALL increment period_cnt_o by 1, wrapping from all-ones to 0.
REQ-021 RUN, cnt_done_i=1, repeat!=0, period_cnt_o+1 == repeat: SHALL enter IDLE and pulse irq_o high for exactly the following cycle.
REQ-022 RUN, stop_i=1: SHALL enter IDLE next edge, no irq_o, no period_cnt_o increment; stop_i SHALL take priority over a simultaneous final cnt_done_i.
REQ-023 start_i in RUN SHALL be ignored; period_i/repeat_i changes in RUN SHALL have no effect.
REQ-024 cnt_done_i in IDLE SHALL be ignored.
REQ-025 cnt_end_val_o and period_cnt_o SHALL hold their values after return to IDLE until the next accepted start.
REQ-026 With a downstream counter that holds 0 while disabled, irq_o SHALL rise exactly period*repeat cycles after the edge that accepted start_i.

Reset
REQ-027 On rst_ni low SHALL asynchronously force IDLE, cnt_enable_o=0, busy_o=0, cnt_end_val_o=0, period_cnt_o=0, irq_o=0, err_o=0.
REQ-028 Reset asserted mid-RUN SHALL abort with no irq_o; after release the block SHALL require a new start_i.

Configuration
REQ-029 Macro USER_CNT_CTRL_AUTORELOAD_EN SHALL select auto-reload.
REQ-030 Defined: on the REQ-021 condition the block SHALL pulse irq_o, re-latch period_i/repeat_i, clear period_cnt_o and stay in RUN; if period_i==0 at that edge it SHALL instead enter IDLE and pulse both irq_o and err_o.
REQ-031 Undefined: REQ-021 behaviour applies unchanged; no reload logic SHALL be present.

Verification
REQ-032 Reset mid-RUN with period 10, repeat 5 after 2 periods -> all outputs 0 immediately, no irq_o, IDLE after release.
REQ-033 Start, period 4, repeat 3, attached counter -> cnt_enable_o high 12 cycles, period_cnt_o 1,2,3, irq_o single pulse 12 cycles after start edge, cnt_end_val_o stays 4.
REQ-034 Start with period_i=0 -> err_o one cycle, busy_o stays 0, cnt_end_val_o unchanged.
REQ-035 Period 3, repeat 0, stop after 260 periods -> period_cnt_o wraps 255->0 reaching 4, no irq_o, busy_o low one edge after stop_i.
REQ-036 Period 5, repeat 2, stop_i coincident with second cnt_done_i -> IDLE, period_cnt_o=1, no irq_o.
REQ-037 With USER_CNT_CTRL_AUTORELOAD_EN, period 4, repeat 2, period_i changed to 6 mid-run -> irq_o at cycle 8, then at cycle 20, cnt_enable_o continuously high until stop_i.
